rv_decode_issue: RTL and testbench

//  Decode/issue stage directly upstream of the RV32 ALU. Accepts one 32-bit instruction per

---
 rtl/rv_pkg.sv | 35 +++
 rtl/rv_regfile.sv | 36 +++
 rtl/rv_decode_issue.sv | 145 ++++++++++++++
 tb/tb_rv_decode_issue.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 constants: ALU op encodings (also used by the ALU), opcode and funct fields.
package rv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t AluAdd  = 4'b0000;
  localparam alu_op_t AluSub  = 4'b0001;
  localparam alu_op_t AluXor  = 4'b0010;
  localparam alu_op_t AluOr   = 4'b0011;
  localparam alu_op_t AluAnd  = 4'b0100;
  localparam alu_op_t AluSll  = 4'b0101;
  localparam alu_op_t AluSrl  = 4'b0111;
  localparam alu_op_t AluSra  = 4'b1000;
  localparam alu_op_t AluSlt  = 4'b1001;
  localparam alu_op_t AluSltu = 4'b1010;

  localparam logic [6:0] OpcodeOp    = 7'b0110011;
  localparam logic [6:0] OpcodeOpImm = 7'b0010011;

  localparam logic [6:0] Funct7Zero = 7'b0000000;
  localparam logic [6:0] Funct7Alt  = 7'b0100000;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3SrlSra = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

endpackage

// File: rtl/rv_regfile.sv
// 2-read 1-write register file, x0 hardwired to zero.
// RV_WB_BYPASS_EN makes a same-cycle write visible on the read ports.
module rv_regfile import rv_pkg::*; (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      raddr_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && waddr != 5'd0) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = (raddr_a == 5'd0) ? '0 : regs_q[raddr_a];
    rdata_b = (raddr_b == 5'd0) ? '0 : regs_q[raddr_b];
`ifdef RV_WB_BYPASS_EN
    if (we && waddr != 5'd0 && raddr_a == waddr) rdata_a = wdata;
    if (we && waddr != 5'd0 && raddr_b == waddr) rdata_b = wdata;
`endif
  end

endmodule

// File: rtl/rv_decode_issue.sv
// Decode/issue stage feeding the RV32 ALU: decodes OP / OP-IMM, reads operands, registers them.
// Optional RV_WB_BYPASS_EN selects write-through reads in the register file.
module rv_decode_issue import rv_pkg::*; (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            illegal,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  logic [XLEN-1:0] rs1_data, rs2_data;

  rv_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (rs1),
    .raddr_b (rs2),
    .rdata_a (rs1_data),
    .rdata_b (rs2_data),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  logic            is_r, is_i, is_shift, f7_zero, f7_alt, dec_legal;
  alu_op_t         dec_op;
  logic [XLEN-1:0] dec_a, dec_b;

  always_comb begin
    is_r     = (opcode == OpcodeOp);
    is_i     = (opcode == OpcodeOpImm);
    is_shift = (funct3 == F3Sll) || (funct3 == F3SrlSra);
    f7_zero  = (funct7 == Funct7Zero);
    f7_alt   = (funct7 == Funct7Alt);

    unique case (funct3)
      F3AddSub: dec_op = (is_r && f7_alt) ? AluSub : AluAdd;
      F3Sll:    dec_op = AluSll;
      F3Slt:    dec_op = AluSlt;
      F3Sltu:   dec_op = AluSltu;
      F3Xor:    dec_op = AluXor;
      F3SrlSra: dec_op = f7_alt ? AluSra : AluSrl;
      F3Or:     dec_op = AluOr;
      default:  dec_op = AluAnd;
    endcase

    // The alternate funct7 is only meaningful for SUB/SRA (R-type) and SRAI (I-type).
    dec_legal = 1'b0;
    if (is_r) begin
      dec_legal = f7_zero || (f7_alt && (funct3 == F3AddSub || funct3 == F3SrlSra));
    end else if (is_i) begin
      dec_legal = !is_shift || f7_zero || (f7_alt && funct3 == F3SrlSra);
    end

    dec_a = rs1_data;
    if (is_r) begin
      dec_b = rs2_data;
    end else if (is_shift) begin
      dec_b = {27'b0, instr[24:20]};
    end else begin
      dec_b = {{20{instr[31]}}, instr[31:20]};
    end

    if (!dec_legal) begin
      dec_op = AluAdd;
      dec_a  = '0;
      dec_b  = '0;
    end
  end

  logic            load, out_valid_d;
  logic            out_valid_q, rd_we_q, illegal_q;
  alu_op_t         alu_op_q;
  logic [XLEN-1:0] alu_a_q, alu_b_q;
  logic [4:0]      rd_addr_q;

  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_valid && in_ready;

  always_comb begin
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= AluAdd;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rd_addr_q   <= '0;
      rd_we_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load) begin
        alu_op_q  <= dec_op;
        alu_a_q   <= dec_a;
        alu_b_q   <= dec_b;
        rd_addr_q <= rd;
        rd_we_q   <= dec_legal && (rd != 5'd0);
        illegal_q <= !dec_legal;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rd_addr   = rd_addr_q;
  assign rd_we     = rd_we_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_rv_decode_issue.sv
// Bench for rv_decode_issue: directed scenarios then random traffic against a reference model.
module tb_rv_decode_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  rd_addr;
  logic        rd_we, illegal;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  rv_decode_issue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .rd_addr   (rd_addr),
    .rd_we     (rd_we),
    .illegal   (illegal),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: architectural registers and the expected output entry.
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_rd;
  logic        m_we, m_ill;

  // ALU op per funct3 for the base (non-alternate) instruction.
  logic [3:0] base_op [8] = '{4'h0, 4'h5, 4'h9, 4'hA, 4'h2, 4'h7, 4'h3, 4'h4};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef RV_WB_BYPASS_EN
    if (wb_we && wb_addr == a) return wb_data;
`endif
    return m_regs[a];
  endfunction

  task automatic model_decode(input logic [31:0] ins, output logic [3:0] op,
                              output logic [31:0] a, output logic [31:0] b,
                              output logic ill);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic       shift;
    opc   = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    ill   = 1'b1;
    op    = base_op[f3];
    a     = m_read(ins[19:15]);
    b     = 32'd0;
    if (opc == 7'h33) begin
      b = m_read(ins[24:20]);
      if (f7 == 7'h00) ill = 1'b0;
      else if (f7 == 7'h20 && f3 == 3'd0) begin ill = 1'b0; op = 4'h1; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin ill = 1'b0; op = 4'h8; end
    end else if (opc == 7'h13) begin
      if (!shift) begin
        ill = 1'b0;
        b   = 32'(signed'(ins[31:20]));
      end else begin
        b = 32'(ins[24:20]);
        if (f7 == 7'h00) ill = 1'b0;
        else if (f7 == 7'h20 && f3 == 3'd5) begin ill = 1'b0; op = 4'h8; end
      end
    end
    if (ill) begin op = 4'h0; a = 32'd0; b = 32'd0; end
  endtask

  task automatic check_out();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("alu_op", 32'(alu_op), 32'(m_op));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("rd_we", 32'(rd_we), 32'(m_we));
      chk("illegal", 32'(illegal), 32'(m_ill));
      if (!m_ill) chk("rd_addr", 32'(rd_addr), 32'(m_rd));
    end
  endtask

  // One clock: check in_ready, advance the model across the edge, check outputs after it.
  task automatic cycle();
    logic       ld;
    logic [3:0] op;
    logic [31:0] a, b;
    logic       ill;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    ld = in_valid && (!m_valid || out_ready);
    model_decode(instr, op, a, b, ill);
    @(posedge clk);
    if (ld) begin
      m_op = op; m_a = a; m_b = b; m_ill = ill;
      m_rd = instr[11:7];
      m_we = !ill && instr[11:7] != 5'd0;
    end
    if (flush) m_valid = 1'b0;
    else if (ld) m_valid = 1'b1;
    else if (out_ready) m_valid = 1'b0;
    if (wb_we && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
    #1;
    check_out();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b0;
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    cycle();
    wb_we = 1'b0;
  endtask

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'h33};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {imm, s1, f3, d, 7'h13};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_rd_we", 32'(rd_we), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
  endtask

  initial begin
    logic [6:0] f7;
    rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0; flush = 1'b0; out_ready = 1'b1;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    model_reset();
    #12;
    check_reset_outputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // add x3,x1,x2 with x1=5, x2=3
    wr(5'd1, 32'd5);
    wr(5'd2, 32'd3);
    instr = r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd3); in_valid = 1'b1;
    cycle();
    chk("t1_a", alu_a, 32'd5);
    chk("t1_b", alu_b, 32'd3);
    chk("t1_rd", 32'(rd_addr), 32'd3);
    in_valid = 1'b0;

    // addi x4,x1,-1 then srai x5,x1,4 back to back
    wr(5'd1, 32'hFFFF_FFF0);
    instr = 32'hFFF0_8213; in_valid = 1'b1;
    cycle();
    chk("t2_addi_b", alu_b, 32'hFFFF_FFFF);
    instr = i_ins({7'h20, 5'd4}, 5'd1, 3'd5, 5'd5);
    cycle();
    chk("t2_srai_op", 32'(alu_op), 32'h8);
    chk("t2_srai_b", alu_b, 32'd4);

    // Backpressure: 3 stalled cycles, then the pending add x8 loads.
    out_ready = 1'b0;
    instr = r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd8);
    for (int i = 0; i < 3; i++) cycle();
    chk("t3_stall_ready", 32'(in_ready), 32'd0);
    chk("t3_stall_rd", 32'(rd_addr), 32'd5);
    out_ready = 1'b1;
    cycle();
    chk("t3_resume_rd", 32'(rd_addr), 32'd8);

    // JAL is illegal; add x0 writes nothing.
    instr = 32'h0000_006F;
    cycle();
    chk("t4_illegal", 32'(illegal), 32'd1);
    chk("t4_ill_a", alu_a, 32'd0);
    instr = r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd0);
    cycle();
    chk("t4_x0_we", 32'(rd_we), 32'd0);

    // Flush wins over a simultaneous load.
    flush = 1'b1;
    instr = r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd9);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_flush_valid", 32'(out_valid), 32'd0);

    // Reset mid-stream clears outputs and the register file.
    in_valid = 1'b1;
    instr = r_ins(7'h00, 5'd2, 5'd1, 3'd4, 5'd10);
    cycle();
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    instr = r_ins(7'h00, 5'd0, 5'd1, 3'd0, 5'd3); in_valid = 1'b1;
    cycle();
    chk("t5_x1_after_rst", alu_a, 32'd0);
    in_valid = 1'b0;

    // Writeback colliding with an operand read.
    wr(5'd6, 32'd2);
    wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'd9;
    instr = r_ins(7'h00, 5'd0, 5'd6, 3'd0, 5'd7); in_valid = 1'b1;
    cycle();
`ifdef RV_WB_BYPASS_EN
    chk("t6_bypass_a", alu_a, 32'd9);
`else
    chk("t6_nobypass_a", alu_a, 32'd2);
`endif
    wb_we = 1'b0; in_valid = 1'b0;

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'($urandom);
        default: f7 = 7'h00;
      endcase
      case ($urandom_range(0, 3))
        0: instr = r_ins(f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         3'($urandom), 5'($urandom_range(0, 7)));
        1: instr = i_ins(12'($urandom), 5'($urandom_range(0, 7)), 3'($urandom),
                         5'($urandom_range(0, 7)));
        2: instr = i_ins({f7, 5'($urandom)}, 5'($urandom_range(0, 7)),
                         ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5, 5'($urandom_range(0, 7)));
        default: instr = $urandom;
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      wb_we     = ($urandom_range(0, 2) == 0);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
